register_file_phased: RTL and testbench
=======================================

Name: register_file_phased

Overview:
- 32 x 32-bit general-purpose register file feeding the ALU operand inputs (readData1/readData2).
- Uses the datapath's shared 10-phase instruction sequencing: an internal phase counter wraps mod NUM_PHASES.
- Operands are captured into output registers at READ_PHASE, ahead of the ALU execute phase (6).
- Write-back is committed at WRITE_PHASE, at the end of the instruction slot. Register 0 is hardwired to zero.

Parameters:
- NUM_PHASES, 10, length of one instruction slot in clock cycles.
- READ_PHASE, 4, phase value on which read ports are sampled; must be less than NUM_PHASES.
- WRITE_PHASE, 9, phase value on which write-back is committed; must be less than NUM_PHASES.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- regWrite  input  1  write enable, sampled only at WRITE_PHASE.
- readRegister1  input  5  source register index, port 1.
- readRegister2  input  5  source register index, port 2.
- writeRegister  input  5  destination register index.
- writeData  input  32  write-back value.
- readData1  output  32  registered operand 1, to ALU.
- readData2  output  32  registered operand 2, to ALU.
- phase  output  4  current phase counter value, for debug and bench alignment.

Behaviour:
- Reset is synchronous, active-high, sampled on a rising clock edge. While asserted:
  - phase <= 0.
  - All 32 registers <= 0.
  - readData1 and readData2 <= 0.
  - No write occurs.
- Reset asserted mid-slot aborts the slot. Any pending write or read on that edge is discarded.
- Phase counter: on every non-reset rising edge, phase_next = (phase + 1) mod NUM_PHASES, and phase <= phase_next.
  - All phase decisions on an edge use phase_next, the post-increment value.
  - The first non-reset edge after reset yields phase = 1.
  - Sequence is 1..9, 0, 1, ... with wrap 9 -> 0.
- Read, on an edge where phase_next == READ_PHASE:
  - readData1 <= reg[readRegister1]; readData2 <= reg[readRegister2].
  - Outputs hold their value on all other edges; one registered capture per slot.
- Read of index 0 always returns 32'h0.
- Write, on an edge where phase_next == WRITE_PHASE, if regWrite == 1 and writeRegister != 0:
  - reg[writeRegister] <= writeData.
  - regWrite is ignored at every other phase.
- A write to index 0 is silently dropped; reg[0] stays 0.
- If READ_PHASE == WRITE_PHASE and a write hits a read address (nonzero) on the same edge, the read returns writeData (write-first bypass). Each port is evaluated independently.
- With the defaults (4 and 9), a write in slot N is visible to the read in slot N+1. There is no same-slot forwarding.
- Latency:
  - From valid read addresses at phase-edge READ_PHASE to outputs updated: same edge, visible the following cycle.
  - Write to readable: the next READ_PHASE edge.
- All arithmetic is unsigned; the 5-bit indices address all 32 entries with no out-of-range case.

Test Plan:
- Reset held 3 cycles, then released -> phase=0, readData1=readData2=0. Phase then steps 1,2,...,9,0,1 on successive edges.
- Write reg[5]=32'hDEADBEEF at phase 9 (regWrite=1, writeRegister=5). In the next slot set readRegister1=5 -> readData1=32'hDEADBEEF after the phase-4 edge; readData2 with readRegister2=0 -> 0.
- regWrite=1, writeRegister=7, writeData=32'h12345678 held through phases 1-8, dropped at phase 9 -> reg[7] unchanged (0), read at phase 4 of the next slot gives 0.
- Write writeRegister=0, writeData=32'hFFFFFFFF at phase 9 -> subsequent read of index 0 returns 0.
- Change readRegister1 from 3 to 4 at phase 6, with reg3=32'h11 and reg4=32'h22 -> readData1 stays 32'h11 until the next phase-4 edge, then becomes 32'h22.
- Preload reg[2]=32'hA5A5A5A5, then assert reset at phase 7 for one cycle -> phase=0, readData1/2=0, and reading reg2 in the next slot returns 0.

Source files
------------

// File: rtl/register_file_phased.sv
// 32 x 32-bit register file driven by the datapath's shared phase counter.
// Operands are captured once per instruction slot; write-back commits once per slot.
module register_file_phased #(
    parameter int NUM_PHASES  = 10,
    parameter int READ_PHASE  = 4,
    parameter int WRITE_PHASE = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        regWrite,
    input  logic [4:0]  readRegister1,
    input  logic [4:0]  readRegister2,
    input  logic [4:0]  writeRegister,
    input  logic [31:0] writeData,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [3:0]  phase
);

    localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES - 1);
    localparam logic [3:0] RD_PHASE   = 4'(READ_PHASE);
    localparam logic [3:0] WR_PHASE   = 4'(WRITE_PHASE);

    logic [31:0] regs [32];
    logic [3:0]  phase_next;
    logic        read_en;
    logic        write_en;

    // Every decision on an edge looks at the phase this edge is about to enter.
    always_comb begin
        phase_next = (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
        read_en    = (phase_next == RD_PHASE);
        write_en   = (phase_next == WR_PHASE) && regWrite && (writeRegister != 5'd0);
    end

    // Write-first bypass only matters when both actions land on the same edge.
    function automatic logic [31:0] read_port(input logic [4:0] idx);
        logic [31:0] value;
        if (idx == 5'd0)
            value = 32'h0;
        else if (write_en && (idx == writeRegister))
            value = writeData;
        else
            value = regs[idx];
        return value;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            phase     <= 4'd0;
            readData1 <= 32'h0;
            readData2 <= 32'h0;
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'h0;
        end else begin
            phase <= phase_next;
            if (read_en) begin
                readData1 <= read_port(readRegister1);
                readData2 <= read_port(readRegister2);
            end
            if (write_en)
                regs[writeRegister] <= writeData;
        end
    end

endmodule

// File: tb/tb_register_file_phased.sv
// Directed bench for register_file_phased: phase sequencing, phased read/write, reset abort.
module tb_register_file_phased;

    logic        clock = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [3:0]  phase;

    int checks = 0;
    int fails  = 0;

    register_file_phased dut (
        .clock        (clock),
        .reset        (reset),
        .regWrite     (regWrite),
        .readRegister1(readRegister1),
        .readRegister2(readRegister2),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readData1    (readData1),
        .readData2    (readData2),
        .phase        (phase)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_phase(input logic [3:0] target);
        int n;
        tick();
        n = 1;
        while (phase !== target && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (phase !== target) begin
            fails++;
            $display("FAIL wait_phase: phase=%0d required=%0d", phase, target);
        end
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] value);
        regWrite      = 1'b1;
        writeRegister = idx;
        writeData     = value;
        wait_phase(4'd9);
        regWrite      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (phase !== 4'd0) begin
            fails++;
            $display("FAIL reset_phase: got %0d required 0", phase);
        end
        checks++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h required 0/0", readData1, readData2);
        end
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (phase !== 4'(k % 10)) begin
                fails++;
                $display("FAIL phase_seq: step %0d got %0d required %0d", k, phase, k % 10);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        readRegister1 = 5'd5;
        readRegister2 = 5'd0;
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read_r5: got %h required deadbeef", readData1);
        end
        checks++;
        if (readData2 !== 32'h0) begin
            fails++;
            $display("FAIL write_read_r0: got %h required 0", readData2);
        end
    endtask

    task automatic test_write_off_phase();
        wait_phase(4'd0);
        regWrite      = 1'b1;
        writeRegister = 5'd7;
        writeData     = 32'h12345678;
        wait_phase(4'd8);
        regWrite = 1'b0;
        tick();
        readRegister1 = 5'd7;
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'h0) begin
            fails++;
            $display("FAIL write_off_phase: got %h required 0", readData1);
        end
    endtask

    task automatic test_write_zero();
        do_write(5'd0, 32'hFFFFFFFF);
        readRegister1 = 5'd0;
        readRegister2 = 5'd5;
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'h0) begin
            fails++;
            $display("FAIL write_zero: got %h required 0", readData1);
        end
        checks++;
        if (readData2 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL port2_r5: got %h required deadbeef", readData2);
        end
    endtask

    task automatic test_read_hold();
        do_write(5'd3, 32'h11);
        do_write(5'd4, 32'h22);
        readRegister1 = 5'd3;
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'h11) begin
            fails++;
            $display("FAIL hold_initial: got %h required 11", readData1);
        end
        wait_phase(4'd6);
        readRegister1 = 5'd4;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (readData1 !== 32'h11) begin
                fails++;
                $display("FAIL hold_phase%0d: got %h required 11", phase, readData1);
            end
        end
        tick();
        checks++;
        if (phase !== 4'd4 || readData1 !== 32'h22) begin
            fails++;
            $display("FAIL hold_update: phase %0d got %h required phase 4 data 22", phase, readData1);
        end
    endtask

    task automatic test_back_to_back();
        do_write(5'd31, 32'h80000001);
        readRegister2 = 5'd31;
        wait_phase(4'd4);
        checks++;
        if (readData2 !== 32'h80000001) begin
            fails++;
            $display("FAIL r31_read: got %h required 80000001", readData2);
        end
        do_write(5'd31, 32'h00000002);
        wait_phase(4'd4);
        checks++;
        if (readData2 !== 32'h00000002) begin
            fails++;
            $display("FAIL r31_overwrite: got %h required 00000002", readData2);
        end
    endtask

    task automatic test_reset_mid();
        do_write(5'd2, 32'hA5A5A5A5);
        readRegister1 = 5'd2;
        readRegister2 = 5'd3;
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL preload_r2: got %h required a5a5a5a5", readData1);
        end
        wait_phase(4'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (phase !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset_phase: got %0d required 0", phase);
        end
        checks++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_data: got %h/%h required 0/0", readData1, readData2);
        end
        wait_phase(4'd4);
        checks++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
            fails++;
            $display("FAIL post_reset_read: got %h/%h required 0/0", readData1, readData2);
        end
    endtask

    initial begin
        reset         = 1'b1;
        regWrite      = 1'b0;
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
        writeRegister = 5'd0;
        writeData     = 32'h0;
        @(negedge clock);
        test_reset();
        test_write_read();
        test_write_off_phase();
        test_write_zero();
        test_read_hold();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
